// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the register file, the execute stage and write-back.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [4:0]       shamt;
  logic [4:0]       dest_reg_in;
  logic             reg_write_in;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic [4:0]       dest_reg_out;
  logic             reg_write_out;
  logic             busy;
  logic             exec_done;

  modport master (
    output en, start, alu_op, operand_a, operand_b, shamt, dest_reg_in, reg_write_in,
    input  result, hi, zero, overflow, dest_reg_out, reg_write_out, busy, exec_done
  );

  modport slave (
    input  en, start, alu_op, operand_a, operand_b, shamt, dest_reg_in, reg_write_in,
    output result, hi, zero, overflow, dest_reg_out, reg_write_out, busy, exec_done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative 32-step shift-add multiplier,
// with registered write-back outputs and a one-cycle exec_done pulse.
module alu_exec_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(MUL_STEPS + 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SUBU  = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_SLL   = 4'd10;
  localparam logic [3:0] OP_SRL   = 4'd11;
  localparam logic [3:0] OP_SRA   = 4'd12;
  localparam logic [3:0] OP_MULT  = 4'd13;
  localparam logic [3:0] OP_MULTU = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_exec_fin, w_mul_step, w_mul_fin;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [4:0]       r_shamt, r_dest;
  logic             r_rw;

  logic [WIDTH-1:0] r_mcand;
  logic [PW-1:0]    r_prod;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_result, r_hi;
  logic             r_zero, r_ovf, r_rw_out, r_done;
  logic [4:0]       r_dest_out;

  logic [WIDTH-1:0] w_sum, w_diff, w_alu, w_a_mag, w_b_mag;
  logic             w_ovf, w_mul_signed;
  logic [WIDTH:0]   w_psum;
  logic [PW-1:0]    w_prod_fin;

  // Control: every transition and datapath action is gated by en
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exec_fin  = 1'b0;
    w_mul_step  = 1'b0;
    w_mul_fin   = 1'b0;
    if (bus.en) begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.alu_op == OP_MULT || bus.alu_op == OP_MULTU) ? S_MUL : S_EXEC;
        end
        S_EXEC: begin
          w_exec_fin  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_MUL: begin
          if (r_cnt == CNT_W'(MUL_STEPS)) begin
            w_mul_fin   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_mul_step  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;

  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu = w_sum;
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_ADDU: w_alu = w_sum;
      OP_SUB: begin
        w_alu = w_diff;
        w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUBU: w_alu = w_diff;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_SLT:  w_alu = WIDTH'($signed(r_a) < $signed(r_b));
      OP_SLTU: w_alu = WIDTH'(r_a < r_b);
      OP_SLL:  w_alu = r_b << r_shamt;
      OP_SRL:  w_alu = r_b >> r_shamt;
      OP_SRA:  w_alu = WIDTH'($signed(r_b) >>> r_shamt);
      default: w_alu = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; 0x80000000 maps to unsigned 2^31
  assign w_mul_signed = (bus.alu_op == OP_MULT);
  assign w_a_mag = (w_mul_signed && bus.operand_a[WIDTH-1]) ? WIDTH'(0) - bus.operand_a : bus.operand_a;
  assign w_b_mag = (w_mul_signed && bus.operand_b[WIDTH-1]) ? WIDTH'(0) - bus.operand_b : bus.operand_b;
  assign w_psum  = {1'b0, r_prod[PW-1:WIDTH]} + {1'b0, r_mcand};
  assign w_prod_fin = r_neg ? PW'(0) - r_prod : r_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_shamt    <= '0;
      r_dest     <= '0;
      r_rw       <= 1'b0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_hi       <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rw_out   <= 1'b0;
      r_dest_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_exec_fin | w_mul_fin;
      if (w_accept) begin
        r_op    <= bus.alu_op;
        r_a     <= bus.operand_a;
        r_b     <= bus.operand_b;
        r_shamt <= bus.shamt;
        r_dest  <= bus.dest_reg_in;
        r_rw    <= bus.reg_write_in;
        r_mcand <= w_a_mag;
        r_prod  <= {WIDTH'(0), w_b_mag};
        r_neg   <= w_mul_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
        r_cnt   <= '0;
      end
      if (w_mul_step) begin
        r_prod <= r_prod[0] ? {w_psum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[PW-1:1]};
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_exec_fin) begin
        r_result   <= w_alu;
        r_zero     <= (w_alu == '0);
        r_ovf      <= w_ovf;
        r_rw_out   <= r_rw & ~w_ovf & (r_op != OP_RSVD);
        r_dest_out <= r_dest;
      end
      if (w_mul_fin) begin
        r_hi       <= w_prod_fin[PW-1:WIDTH];
        r_result   <= w_prod_fin[WIDTH-1:0];
        r_zero     <= (w_prod_fin[WIDTH-1:0] == '0);
        r_ovf      <= 1'b0;
        r_rw_out   <= 1'b0;
        r_dest_out <= r_dest;
      end
    end
  end

  assign bus.result        = r_result;
  assign bus.hi            = r_hi;
  assign bus.zero          = r_zero;
  assign bus.overflow      = r_ovf;
  assign bus.dest_reg_out  = r_dest_out;
  assign bus.reg_write_out = r_rw_out;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.exec_done     = r_done;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: cycle-level behavioural model with per-cycle compare,
// plus directed vectors with hand-computed expectations.
module tb_alu_exec_unit;
  localparam logic [3:0] ADD = 4'd0, ADDU = 4'd1, SUB = 4'd2, SUBU = 4'd3, AND_ = 4'd4,
                         OR_ = 4'd5, XOR_ = 4'd6, NOR_ = 4'd7, SLT = 4'd8, SLTU = 4'd9,
                         SLL = 4'd10, SRL = 4'd11, SRA = 4'd12, MULT = 4'd13, MULTU = 4'd14,
                         RSVD = 4'd15;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32)) u_if ();
  alu_exec_unit #(.WIDTH(32), .MUL_STEPS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));

  int n_chk = 0, n_pass = 0, n_done = 0, cyc = 0, acc = 0, lat = 0, d0 = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Small register file on the write-back path
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd100;
      rf[2] <= 32'd200;
    end else if (u_if.exec_done && u_if.reg_write_out && u_if.dest_reg_out != 5'd0) begin
      rf[u_if.dest_reg_out] <= u_if.result;
    end
  end

  // Model: a pending instruction completes after a fixed number of enabled edges
  logic [31:0] m_result, m_hi, m_a, m_b;
  logic        m_zero, m_ovf, m_rw, m_done, m_busy, m_rw_in;
  logic [4:0]  m_dest, m_dest_in, m_sh;
  logic [3:0]  m_op;
  int          m_rem;

  task automatic model_complete();
    longint sa, sb, s;
    logic [63:0] p;
    logic signed [31:0] t;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    m_ovf = 1'b0;
    case (m_op)
      ADD, SUB: begin
        s = (m_op == ADD) ? sa + sb : sa - sb;
        m_result = s[31:0];
        m_ovf = (s > SMAX) || (s < SMIN);
      end
      ADDU: m_result = m_a + m_b;
      SUBU: m_result = m_a - m_b;
      AND_: m_result = m_a & m_b;
      OR_:  m_result = m_a | m_b;
      XOR_: m_result = m_a ^ m_b;
      NOR_: m_result = ~(m_a | m_b);
      SLT:  m_result = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: m_result = (m_a < m_b) ? 32'd1 : 32'd0;
      SLL:  m_result = m_b << m_sh;
      SRL:  m_result = m_b >> m_sh;
      SRA: begin t = m_b; m_result = t >>> m_sh; end
      MULT, MULTU: begin
        if (m_op == MULT) begin s = sa * sb; p = s; end
        else p = {32'd0, m_a} * {32'd0, m_b};
        m_hi = p[63:32];
        m_result = p[31:0];
      end
      default: m_result = 32'd0;
    endcase
    m_zero = (m_result == 32'd0);
    m_dest = m_dest_in;
    m_rw   = m_rw_in && !m_ovf && (m_op < MULT);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_result = 0; m_hi = 0; m_zero = 0; m_ovf = 0; m_rw = 0; m_dest = 0;
      m_done = 0; m_busy = 0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (u_if.en) begin
          m_rem--;
          if (m_rem == 0) begin
            model_complete();
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end else if (u_if.en && u_if.start) begin
        m_op = u_if.alu_op; m_a = u_if.operand_a; m_b = u_if.operand_b; m_sh = u_if.shamt;
        m_dest_in = u_if.dest_reg_in; m_rw_in = u_if.reg_write_in;
        m_busy = 1'b1;
        m_rem = (m_op == MULT || m_op == MULTU) ? 33 : 1;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("exec_done", 64'(u_if.exec_done), 64'(m_done));
      chk("busy", 64'(u_if.busy), 64'(m_busy));
      chk("result", 64'(u_if.result), 64'(m_result));
      chk("hi", 64'(u_if.hi), 64'(m_hi));
      chk("zero", 64'(u_if.zero), 64'(m_zero));
      chk("overflow", 64'(u_if.overflow), 64'(m_ovf));
      chk("dest_reg_out", 64'(u_if.dest_reg_out), 64'(m_dest));
      chk("reg_write_out", 64'(u_if.reg_write_out), 64'(m_rw));
      if (u_if.exec_done === 1'b1) n_done++;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] dest, input logic rw);
    u_if.alu_op = op; u_if.operand_a = a; u_if.operand_b = b;
    u_if.shamt = sh; u_if.dest_reg_in = dest; u_if.reg_write_in = rw;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input string name);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u_if.exec_done === 1'b1) begin lat = cyc - acc; break; end
    end
    if (lat < 0) chk({name, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic single(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    issue(op, a, b, sh, 5'd7, 1'b1);
    wait_done(name);
    chk({name, " latency"}, 64'(lat), 64'd1);
    chk(name, 64'(u_if.result), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; u_if.en = 1'b1; u_if.start = 1'b0; u_if.alu_op = 4'd0;
    u_if.operand_a = 32'd0; u_if.operand_b = 32'd0; u_if.shamt = 5'd0;
    u_if.dest_reg_in = 5'd0; u_if.reg_write_in = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a multiply
    issue(MULT, 32'd9, 32'd9, 5'd0, 5'd1, 1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0; d0 = n_done;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(u_if.busy), 64'd0);
    chk("rst result", 64'(u_if.result), 64'd0);
    chk("rst hi", 64'(u_if.hi), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst no done", 64'(n_done - d0), 64'd0);

    // ADD from register file outputs, write-back into x3
    issue(ADD, rf[1], rf[2], 5'd0, 5'd3, 1'b1);
    wait_done("add");
    chk("add latency", 64'(lat), 64'd1);
    chk("add result", 64'(u_if.result), 64'd300);
    chk("add dest", 64'(u_if.dest_reg_out), 64'd3);
    chk("add rw", 64'(u_if.reg_write_out), 64'd1);
    @(negedge clk);
    chk("add pulse width", 64'(u_if.exec_done), 64'd0);
    chk("rf x3", 64'(rf[3]), 64'd300);

    // Overflow traps write-back
    issue(ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd4, 1'b1);
    wait_done("add ovf");
    chk("add ovf result", 64'(u_if.result), 64'h8000_0000);
    chk("add ovf flag", 64'(u_if.overflow), 64'd1);
    chk("add ovf rw", 64'(u_if.reg_write_out), 64'd0);
    issue(ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd4, 1'b1);
    wait_done("addu");
    chk("addu ovf flag", 64'(u_if.overflow), 64'd0);
    chk("addu rw", 64'(u_if.reg_write_out), 64'd1);
    issue(SUB, 32'h8000_0000, 32'd1, 5'd0, 5'd4, 1'b1);
    wait_done("sub ovf");
    chk("sub ovf flag", 64'(u_if.overflow), 64'd1);
    chk("sub ovf result", 64'(u_if.result), 64'h7FFF_FFFF);

    // Compare, shift and logic
    single("slt", SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    single("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
    single("sra", SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    single("srl", SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
    single("sll", SLL, 32'd0, 32'h0000_0003, 5'd31, 32'h8000_0000);
    single("and", AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234);
    single("or", OR_, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F);
    single("xor", XOR_, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0, 32'h00FF_FF00);
    single("nor", NOR_, 32'h0000_FFFF, 32'h00FF_0000, 5'd0, 32'hFF00_0000);
    single("subu", SUBU, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);
    single("sub zero", SUB, 32'd5, 32'd5, 5'd0, 32'd0);
    chk("sub zero flag", 64'(u_if.zero), 64'd1);
    single("rsvd", RSVD, 32'd1, 32'd2, 5'd0, 32'd0);
    chk("rsvd rw", 64'(u_if.reg_write_out), 64'd0);

    // Multiply
    issue(MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 5'd5, 1'b1);
    wait_done("mult");
    chk("mult latency", 64'(lat), 64'd33);
    chk("mult product", {u_if.hi, u_if.result}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult rw", 64'(u_if.reg_write_out), 64'd0);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd5, 1'b1);
    wait_done("multu");
    chk("multu product", {u_if.hi, u_if.result}, 64'h0000_0001_FFFF_FFFE);
    issue(MULT, 32'h8000_0000, 32'h8000_0000, 5'd0, 5'd5, 1'b1);
    wait_done("mult min");
    chk("mult min product", {u_if.hi, u_if.result}, 64'h4000_0000_0000_0000);
    chk("mult min zero", 64'(u_if.zero), 64'd1);
    issue(MULT, 32'h8000_0000, 32'd1, 5'd0, 5'd5, 1'b1);
    wait_done("mult min1");
    chk("mult min1 product", {u_if.hi, u_if.result}, 64'hFFFF_FFFF_8000_0000);

    // Stall mid-multiply
    issue(MULT, 32'd5, 32'd6, 5'd0, 5'd5, 1'b1);
    repeat (10) @(negedge clk);
    u_if.en = 1'b0;
    repeat (5) @(negedge clk);
    u_if.en = 1'b1;
    wait_done("stall");
    chk("stall latency", 64'(lat), 64'd38);
    chk("stall product", 64'(u_if.result), 64'd30);

    // start while busy is ignored
    issue(MULTU, 32'd11, 32'd3, 5'd0, 5'd5, 1'b1);
    repeat (5) @(negedge clk);
    u_if.alu_op = ADD; u_if.operand_a = 32'd1; u_if.operand_b = 32'd1; u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    d0 = n_done;
    wait_done("busy ign");
    chk("busy ign latency", 64'(lat), 64'd33);
    chk("busy ign result", 64'(u_if.result), 64'd33);
    repeat (5) @(negedge clk);
    chk("busy ign one done", 64'(n_done - d0), 64'd1);
    chk("busy ign held", 64'(u_if.result), 64'd33);

    // en drops while exec_done is high
    issue(ADDU, 32'd2, 32'd3, 5'd0, 5'd6, 1'b1);
    wait_done("en drop");
    u_if.en = 1'b0;
    @(negedge clk);
    chk("en drop pulse ends", 64'(u_if.exec_done), 64'd0);
    chk("en drop held", 64'(u_if.result), 64'd5);
    u_if.en = 1'b1;

    // Write-back to x0
    issue(ADD, rf[1], rf[2], 5'd0, 5'd0, 1'b1);
    wait_done("x0");
    chk("x0 rw", 64'(u_if.reg_write_out), 64'd1);
    chk("x0 dest", 64'(u_if.dest_reg_out), 64'd0);
    chk("x0 result", 64'(u_if.result), 64'd300);

    // Reset clears held outputs
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("final rst result", 64'(u_if.result), 64'd0);
    chk("final rst rw", 64'(u_if.reg_write_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
